// File: rtl/masked_pkg.sv
// Shared types and constants for the masked half-word collector and its join stage.
package masked_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HAVE_LO = 2'd1,
        FULL    = 2'd2
    } collect_state_t;

    // Index into the two-entry half bank: low half is entry 0, high half entry 1.
    localparam logic LO_HALF = 1'b0;
    localparam logic HI_HALF = 1'b1;

endpackage : masked_pkg

// File: rtl/masked_join_bv.sv
// Joins a low/high half bank into full-width share vectors, high half in upper bits.
module masked_join_bv
    import masked_pkg::*;
#(
    parameter  int unsigned NUM_SHARES = 2,
    parameter  int unsigned HALF_WIDTH = 15,
    localparam int unsigned BIT_WIDTH  = 2 * HALF_WIDTH
) (
    input  logic [1:0][NUM_SHARES-1:0][HALF_WIDTH-1:0] in_halves,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]       out_b
);

    // Each share is concatenated on its own; shares never interact.
    for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
        assign out_b[s] = {in_halves[HI_HALF][s], in_halves[LO_HALF][s]};
    end

endmodule : masked_join_bv

// File: rtl/masked_half_collect.sv
// Serial-to-parallel collector: two half-width masked words in, one joined word out.
// Optional MASKED_COLLECT_CLEAR_EN wipes the half bank on consume and gates out_b with out_valid.
module masked_half_collect
    import masked_pkg::*;
#(
    parameter  int unsigned NUM_SHARES = 2,
    parameter  int unsigned HALF_WIDTH = 15,
    localparam int unsigned BIT_WIDTH  = 2 * HALF_WIDTH
) (
    input  logic                                 in_clock,
    input  logic                                 in_reset,
    input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] in_a,
    input  logic                                 in_valid,
    output logic                                 out_ready,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  out_b,
    output logic                                 out_valid,
    input  logic                                 in_ready
);

    collect_state_t                         state_q, state_d;
    logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]  lo_q, lo_d;
    logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]  hi_q, hi_d;
    logic                                   out_valid_q, out_valid_d;
    logic                                   accept_c;
    logic                                   consume_c;
    logic [1:0][NUM_SHARES-1:0][HALF_WIDTH-1:0] half_bank_c;

    // Ready passes in_ready straight through while a word is held, so streaming costs no bubble.
    assign out_ready = !in_reset && ((state_q != FULL) || in_ready);
    assign accept_c  = in_valid && out_ready;
    assign consume_c = out_valid_q && in_ready;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        unique case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    lo_d    = in_a;
                    state_d = HAVE_LO;
                end
            end
            HAVE_LO: begin
                if (accept_c) begin
                    hi_d    = in_a;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (consume_c) begin
`ifdef MASKED_COLLECT_CLEAR_EN
                    lo_d = '0;
                    hi_d = '0;
`endif
                    state_d = EMPTY;
                    if (accept_c) begin
                        lo_d    = in_a;
                        state_d = HAVE_LO;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        out_valid_d = (state_d == FULL);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q     <= EMPTY;
            lo_q        <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MASKED_COLLECT_CLEAR_EN
    // Shares only reach the output while a complete word is presented.
    for (genvar s = 0; s < NUM_SHARES; s++) begin : g_gate
        assign half_bank_c[LO_HALF][s] = out_valid_q ? lo_q[s] : '0;
        assign half_bank_c[HI_HALF][s] = out_valid_q ? hi_q[s] : '0;
    end
`else
    assign half_bank_c = {hi_q, lo_q};
`endif

    masked_join_bv #(
        .NUM_SHARES (NUM_SHARES),
        .HALF_WIDTH (HALF_WIDTH)
    ) u_join (
        .in_halves (half_bank_c),
        .out_b     (out_b)
    );

    assign out_valid = out_valid_q;

endmodule : masked_half_collect

// File: tb/tb_masked_half_collect.sv
// Directed bench for masked_half_collect with a queue-based reference model checked every cycle.
module tb_masked_half_collect;

    localparam int unsigned NS = 2;
    localparam int unsigned HW = 15;
    localparam int unsigned BW = 2 * HW;

    typedef logic [NS-1:0][HW-1:0] half_t;
    typedef logic [NS-1:0][BW-1:0] word_t;

    logic  in_clock = 1'b0;
    logic  in_reset;
    half_t in_a;
    logic  in_valid;
    logic  out_ready;
    word_t out_b;
    logic  out_valid;
    logic  in_ready;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    half_t m_q[$];

    masked_half_collect #(.NUM_SHARES(NS), .HALF_WIDTH(HW)) dut (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_a      (in_a),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_valid (out_valid),
        .in_ready  (in_ready)
    );

    always #5 in_clock = ~in_clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word exists once two halves have been collected since the last consume/reset.
    always @(posedge in_clock) begin
        bit full, cons, acc;
        if (in_reset) begin
            m_q.delete();
        end else begin
            full = (m_q.size() == 2);
            cons = full && in_ready;
            acc  = in_valid && (!full || in_ready);
            if (cons) m_q.delete();
            if (acc)  m_q.push_back(in_a);
        end
    end

    initial begin
        forever begin
            @(posedge in_clock);
            #2;
            if (chk_en) begin
                bit    exp_valid;
                word_t exp_w;
                exp_valid = (m_q.size() == 2);
                chk("model_valid", 64'(out_valid), 64'(exp_valid));
                chk("model_ready", 64'(out_ready), 64'(!in_reset && (!exp_valid || in_ready)));
                if (exp_valid) begin
                    for (int s = 0; s < int'(NS); s++)
                        exp_w[s] = {m_q[1][s], m_q[0][s]};
                    chk("model_word", 64'(out_b), 64'(exp_w));
                end
`ifdef MASKED_COLLECT_CLEAR_EN
                else begin
                    chk("model_clear", 64'(out_b), 64'd0);
                end
`endif
            end
        end
    end

    task automatic drive(input bit v, input logic [HW-1:0] s0, input logic [HW-1:0] s1);
        in_valid = v;
        in_a[0]  = s0;
        in_a[1]  = s1;
    endtask

    initial begin
        int pulses;
        in_reset = 1'b1;
        in_ready = 1'b0;
        drive(1'b0, '0, '0);

        // Reset held two cycles
        repeat (2) @(negedge in_clock);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(out_ready), 64'd0);
        chk("rst_out_b", 64'(out_b), 64'd0);
        chk_en   = 1'b1;
        in_reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(out_ready), 64'd1);

        // Single word
        @(negedge in_clock);
        drive(1'b1, 15'h1234, 15'h0F0F);
        @(negedge in_clock);
        chk("lo_only_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 15'h7FFF, 15'h0001);
        @(negedge in_clock);
        drive(1'b0, 15'h5555, 15'h2AAA);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_b0", 64'(out_b[0]), 64'h3FFF_9234);
        chk("single_b1", 64'(out_b[1]), 64'h0000_8F0F);
        chk("full_ready", 64'(out_ready), 64'd0);

        // Backpressure with toggling input
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, HW'(k * 16'h1111), HW'(~(k * 16'h0101)));
            @(negedge in_clock);
            chk("bp_b0", 64'(out_b[0]), 64'h3FFF_9234);
            chk("bp_b1", 64'(out_b[1]), 64'h0000_8F0F);
        end
        drive(1'b0, '0, '0);
        in_ready = 1'b1;
        @(negedge in_clock);
        chk("consumed_valid", 64'(out_valid), 64'd0);
`ifdef MASKED_COLLECT_CLEAR_EN
        chk("cleared_b0", 64'(out_b[0]), 64'd0);
`else
        chk("retained_b0", 64'(out_b[0]), 64'h3FFF_9234);
        chk("retained_b1", 64'(out_b[1]), 64'h0000_8F0F);
`endif

        // Streaming: 6 halves, consume tied high
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) pulses++;
            if (k == 2) chk("stream_w0_b0", 64'(out_b[0]), 64'h0180_0100);
            drive(1'b1, HW'(((k % 2) ? 16'h0300 : 16'h0100) + k / 2),
                        HW'(((k % 2) ? 16'h0400 : 16'h0200) + k / 2));
            @(negedge in_clock);
        end
        if (out_valid) pulses++;
        drive(1'b0, '0, '0);
        repeat (2) begin
            @(negedge in_clock);
            if (out_valid) pulses++;
        end
        chk("stream_pulses", 64'(pulses), 64'd3);

        // Reset mid-word discards the pending low half
        drive(1'b1, 15'h7777, 15'h6666);
        @(negedge in_clock);
        drive(1'b0, '0, '0);
        in_reset = 1'b1;
        @(negedge in_clock);
        in_reset = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        in_ready = 1'b0;
        drive(1'b1, 15'h0AAA, 15'h0555);
        @(negedge in_clock);
        drive(1'b1, 15'h1111, 15'h2222);
        @(negedge in_clock);
        drive(1'b0, 15'h7FFF, 15'h7FFF);
        chk("fresh_valid", 64'(out_valid), 64'd1);
        chk("fresh_b0", 64'(out_b[0]), 64'h0888_8AAA);
        chk("fresh_b1", 64'(out_b[1]), 64'h1111_0555);
        @(negedge in_clock);
        in_ready = 1'b1;
        @(negedge in_clock);
        chk("final_valid", 64'(out_valid), 64'd0);
        in_ready = 1'b0;
        repeat (2) @(negedge in_clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_masked_half_collect
